// File: rtl/mem_lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the memory-stage load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0011;
  localparam logic [3:0] SZ_W = 4'b1111;

  // Replicate the store operand across every lane it could land in.
  function automatic logic [31:0] store_lanes(input logic [3:0] mask, input logic [31:0] d);
    if (mask == SZ_B)      store_lanes = {4{d[7:0]}};
    else if (mask == SZ_H) store_lanes = {2{d[15:0]}};
    else                   store_lanes = d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lsu_if.sv
// ============================================================================
// Module      : mem_lsu_if
// Description : Request/ready data-memory port between the LSU and memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_lsu_if;
  logic        dm_req;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ready, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ready, dm_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_lsu_load_align.sv
// ============================================================================
// Module      : lsu_load_align
// Description : Shifts the read word to the addressed lane and extends by func3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_result
);

  logic [31:0] w_shift;

  assign w_shift = i_rdata >> {i_off, 3'b000};

  always_comb begin
    case (i_func3)
      F3_LB:   o_result = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_LH:   o_result = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_LBU:  o_result = {24'd0, w_shift[7:0]};
      F3_LHU:  o_result = {16'd0, w_shift[15:0]};
      default: o_result = w_shift;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
// Module      : mem_lsu
// Description : Memory-stage load/store unit with stall, misalign and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lsu
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_out_reg,
  input  logic [31:0] rs2_data_reg,
  input  logic [3:0]  dm_w_en_reg,
  input  logic [2:0]  func3_reg,
  input  logic        wb_sel_reg,
  input  logic        wb_en_reg,
  mem_lsu_if.master   dm,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        mem_stall,
  output logic        misalign_exc,
  output logic [31:0] misalign_addr,
  output logic        bus_err
);

  localparam logic [7:0] c_last = 8'(MAX_WAIT - 1);

  lsu_state_t  r_state, w_next;
  logic [7:0]  r_cnt;
  logic [1:0]  r_off;
  logic        r_load;
  logic        r_dm_req;
  logic [3:0]  r_dm_we;
  logic [31:0] r_dm_addr, r_dm_wdata, r_ld_data;
  logic        r_ld_valid, r_bus_err;

  logic        w_store, w_load, w_access, w_half, w_word, w_misalign;
  logic        w_start, w_hit, w_timeout;
  logic [31:0] w_ext;

  assign w_store  = (dm_w_en_reg != 4'd0);
  assign w_load   = wb_sel_reg & wb_en_reg & ~w_store;
  assign w_access = w_store | w_load;

  // Stores size by mask, loads by func3; illegal func3 values count as word.
  assign w_half = w_store ? (dm_w_en_reg == SZ_H)
                          : (func3_reg == F3_LH || func3_reg == F3_LHU);
  assign w_word = w_store ? (dm_w_en_reg == SZ_W)
                          : !(func3_reg inside {F3_LB, F3_LH, F3_LBU, F3_LHU});
  assign w_misalign = (w_half & alu_out_reg[0]) | (w_word & (|alu_out_reg[1:0]));

  lsu_load_align u_load_align (
    .i_rdata  (dm.dm_rdata),
    .i_off    (r_off),
    .i_func3  (func3_reg),
    .o_result (w_ext)
  );

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    mem_stall     = 1'b0;
    misalign_exc  = 1'b0;
    misalign_addr = 32'd0;
    w_start       = 1'b0;
    w_hit         = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access && w_misalign) begin
          misalign_exc  = 1'b1;
          misalign_addr = alu_out_reg;
        end else if (w_access) begin
          mem_stall = 1'b1;
          w_start   = 1'b1;
          w_next    = S_REQ;
        end
      end
      S_REQ: begin
        mem_stall = 1'b1;
        if (dm.dm_ready) begin
          w_hit  = 1'b1;
          w_next = S_DONE;
        end else if (r_cnt == c_last) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= 8'd0;
      r_off      <= 2'd0;
      r_load     <= 1'b0;
      r_dm_req   <= 1'b0;
      r_dm_we    <= 4'd0;
      r_dm_addr  <= 32'd0;
      r_dm_wdata <= 32'd0;
      r_ld_data  <= 32'd0;
      r_ld_valid <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_ld_valid <= 1'b0;
      r_bus_err  <= 1'b0;
      if (w_start) begin
        r_dm_addr  <= {alu_out_reg[31:2], 2'b00};
        r_dm_we    <= dm_w_en_reg << alu_out_reg[1:0];
        r_dm_wdata <= store_lanes(dm_w_en_reg, rs2_data_reg);
        r_off      <= alu_out_reg[1:0];
        r_load     <= w_load;
        r_cnt      <= 8'd0;
        r_dm_req   <= 1'b1;
      end
      if (r_state == S_REQ && !w_hit && !w_timeout) r_cnt <= r_cnt + 8'd1;
      if (w_hit) begin
        r_dm_req   <= 1'b0;
        r_ld_valid <= r_load;
        if (r_load) r_ld_data <= w_ext;
      end
      if (w_timeout) begin
        r_dm_req   <= 1'b0;
        r_ld_valid <= r_load;
        r_ld_data  <= 32'd0;
        r_bus_err  <= 1'b1;
      end
    end
  end

  assign dm.dm_req   = r_dm_req;
  assign dm.dm_we    = r_dm_we;
  assign dm.dm_addr  = r_dm_addr;
  assign dm.dm_wdata = r_dm_wdata;
  assign ld_data     = r_ld_data;
  assign ld_valid    = r_ld_valid;
  assign bus_err     = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
// Module      : tb_mem_lsu
// Description : Scoreboard bench for mem_lsu; DUT state changes on falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_lsu;

  logic        clk = 1'b1;
  logic        rst = 1'b0;
  logic [31:0] alu_out_reg = '0, rs2_data_reg = '0;
  logic [3:0]  dm_w_en_reg = '0;
  logic [2:0]  func3_reg = '0;
  logic        wb_sel_reg = 1'b0, wb_en_reg = 1'b0;
  logic [31:0] ld_data, misalign_addr;
  logic        ld_valid, mem_stall, misalign_exc, bus_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] ld;
    bit          load;
    bit          berr;
  } exp_t;

  exp_t sb[$];

  mem_lsu_if dm_bus ();

  mem_lsu #(.MAX_WAIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_out_reg   (alu_out_reg),
    .rs2_data_reg  (rs2_data_reg),
    .dm_w_en_reg   (dm_w_en_reg),
    .func3_reg     (func3_reg),
    .wb_sel_reg    (wb_sel_reg),
    .wb_en_reg     (wb_en_reg),
    .dm            (dm_bus.master),
    .ld_data       (ld_data),
    .ld_valid      (ld_valid),
    .mem_stall     (mem_stall),
    .misalign_exc  (misalign_exc),
    .misalign_addr (misalign_addr),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                              input logic [31:0] ld, input bit load, input bit berr);
    exp_t e;
    e.addr = a; e.we = we; e.wdata = wd; e.ld = ld; e.load = load; e.berr = berr;
    return e;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input logic [2:0] f3);
    alu_out_reg  = a;
    rs2_data_reg = d;
    dm_w_en_reg  = m;
    func3_reg    = f3;
    wb_sel_reg   = (m == 4'd0);
    wb_en_reg    = (m == 4'd0);
  endtask

  task automatic clear_inputs();
    drive(32'd0, 32'd0, 4'd0, 3'd0);
    wb_sel_reg = 1'b0;
    wb_en_reg  = 1'b0;
    dm_bus.dm_ready = 1'b0;
  endtask

  // Runs one access; memory answers after `waits` REQ cycles.
  task automatic do_access(input string nm, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m, input logic [2:0] f3, input int waits,
                           input logic [31:0] rd, input exp_t e, input int exp_stall,
                           input int exp_req);
    int stall = 0, req = 0, vcnt = 0, bcnt = 0;
    bit done = 0, seen = 0;
    exp_t got;
    sb.push_back(e);
    @(negedge clk); #1;
    drive(a, d, m, f3);
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk);
      if (ld_valid) vcnt++;
      if (bus_err) bcnt++;
      if (dm_bus.dm_req) begin
        if (!seen) begin
          seen = 1;
          n_checks++;
          if (dm_bus.dm_addr !== sb[0].addr || dm_bus.dm_we !== sb[0].we ||
              dm_bus.dm_wdata !== sb[0].wdata) begin
            n_errors++;
            $display("FAIL %s bus got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h", nm,
                     dm_bus.dm_addr, dm_bus.dm_we, dm_bus.dm_wdata, sb[0].addr, sb[0].we, sb[0].wdata);
          end
        end
        dm_bus.dm_ready = (req >= waits);
        dm_bus.dm_rdata = rd;
        req++;
      end else begin
        dm_bus.dm_ready = 1'b0;
      end
      if (mem_stall) stall++;
      else if (stall > 0) done = 1;
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL %s timeout got stall=%0d want completion", nm, stall);
    end
    got = sb.pop_front();
    n_checks++;
    if (got.load && ld_data !== got.ld) begin
      n_errors++;
      $display("FAIL %s ld_data got %h want %h", nm, ld_data, got.ld);
    end
    n_checks++;
    if (stall !== exp_stall || req !== exp_req) begin
      n_errors++;
      $display("FAIL %s timing got stall=%0d req=%0d want stall=%0d req=%0d", nm, stall, req,
               exp_stall, exp_req);
    end
    n_checks++;
    if (vcnt !== int'(got.load) || bcnt !== int'(got.berr)) begin
      n_errors++;
      $display("FAIL %s pulses got ld_valid=%0d bus_err=%0d want %0d %0d", nm, vcnt, bcnt,
               got.load, got.berr);
    end
    @(negedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    @(posedge clk);
    n_checks++;
    if ({dm_bus.dm_req, dm_bus.dm_we, dm_bus.dm_addr, dm_bus.dm_wdata, ld_data, ld_valid,
         bus_err, mem_stall, misalign_exc, misalign_addr} !== '0) begin
      n_errors++;
      $display("FAIL reset outputs got req=%b we=%b addr=%h wdata=%h ld=%h want all 0",
               dm_bus.dm_req, dm_bus.dm_we, dm_bus.dm_addr, dm_bus.dm_wdata, ld_data);
    end
    @(posedge clk);
    rst = 1'b1;
  endtask

  task automatic test_stores();
    do_access("sw", 32'h100, 32'hDEADBEEF, 4'b1111, 3'b010, 0, 32'h0,
              mk(32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 0), 2, 1);
    do_access("sb", 32'h103, 32'h000000A5, 4'b0001, 3'b000, 0, 32'h0,
              mk(32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0, 0, 0), 2, 1);
  endtask

  task automatic test_loads();
    do_access("lb", 32'h202, 32'h0, 4'd0, 3'b000, 3, 32'h80F01234,
              mk(32'h200, 4'd0, 32'h0, 32'hFFFFFFF0, 1, 0), 5, 4);
    do_access("lbu", 32'h202, 32'h0, 4'd0, 3'b100, 3, 32'h80F01234,
              mk(32'h200, 4'd0, 32'h0, 32'h000000F0, 1, 0), 5, 4);
    do_access("lh", 32'h202, 32'h0, 4'd0, 3'b001, 3, 32'h80F01234,
              mk(32'h200, 4'd0, 32'h0, 32'hFFFF80F0, 1, 0), 5, 4);
    do_access("lhu", 32'h202, 32'h0, 4'd0, 3'b101, 3, 32'h80F01234,
              mk(32'h200, 4'd0, 32'h0, 32'h000080F0, 1, 0), 5, 4);
    @(posedge clk);
    n_checks++;
    if (ld_data !== 32'h000080F0 || ld_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL ld_hold got ld=%h valid=%b want 000080f0 0", ld_data, ld_valid);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [2] = '{32'h102, 32'h301};
    int reqs = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      if (k == 0) drive(addrs[k], 32'h0, 4'd0, 3'b010);
      else        drive(addrs[k], 32'h1234, 4'b0011, 3'b001);
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        if (dm_bus.dm_req) reqs++;
        n_checks++;
        if (misalign_exc !== 1'b1 || misalign_addr !== addrs[k] || mem_stall !== 1'b0) begin
          n_errors++;
          $display("FAIL misalign%0d got exc=%b addr=%h stall=%b want 1 %h 0", k,
                   misalign_exc, misalign_addr, mem_stall, addrs[k]);
        end
      end
    end
    @(negedge clk); #1;
    clear_inputs();
    @(posedge clk);
    n_checks++;
    if (reqs !== 0 || misalign_exc !== 1'b0 || misalign_addr !== 32'd0) begin
      n_errors++;
      $display("FAIL misalign_end got reqs=%0d exc=%b addr=%h want 0 0 0", reqs, misalign_exc,
               misalign_addr);
    end
  endtask

  task automatic test_timeout();
    do_access("timeout", 32'h40, 32'h0, 4'd0, 3'b010, 1000, 32'hCAFEF00D,
              mk(32'h40, 4'd0, 32'h0, 32'h0, 1, 1), 5, 4);
    @(posedge clk);
    n_checks++;
    if (dm_bus.dm_req !== 1'b0 || mem_stall !== 1'b0 || bus_err !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_idle got req=%b stall=%b berr=%b want 0 0 0", dm_bus.dm_req,
               mem_stall, bus_err);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); #1;
    drive(32'h0, 32'h0, 4'd0, 3'b010);
    dm_bus.dm_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (dm_bus.dm_req !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_pre got req=%b want 1", dm_bus.dm_req);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (dm_bus.dm_req !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid got req=%b want 0", dm_bus.dm_req);
    end
    clear_inputs();
    @(posedge clk);
    rst = 1'b1;
    do_access("lw_after_rst", 32'h0, 32'h0, 4'd0, 3'b010, 0, 32'h12345678,
              mk(32'h0, 4'd0, 32'h0, 32'h12345678, 1, 0), 2, 1);
  endtask

  initial begin
    dm_bus.dm_ready = 1'b0;
    dm_bus.dm_rdata = 32'h0;
    test_reset();
    test_stores();
    test_loads();
    test_misalign();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit. Sits directly downstream of the execute/memory pipeline register and consumes its registered outputs: address, store data, byte-write enable, func3 and writeback control.
- Drives a request/ready data-memory port, aligns store data into byte lanes, and extracts/extends load data by func3.
- Stalls the pipeline while an access is outstanding and flags misaligned accesses and memory timeouts.

Parameters:
- MAX_WAIT, 255, cycles in REQ without dm_ready before bus error (1..255; counter is 8 bits).

Ports:
- clk  in  1  clock; all state updates on falling edge, same edge as pipeline registers
- rst  in  1  reset, asynchronous, active-low
- alu_out_reg  in  32  effective byte address
- rs2_data_reg  in  32  store source data
- dm_w_en_reg  in  4  store size mask at lane 0: 0001 byte, 0011 half, 1111 word, 0000 no store
- func3_reg  in  3  load/store width and sign
- wb_sel_reg  in  1  1 = writeback from memory (load)
- wb_en_reg  in  1  writeback enable
- dm_req  out  1  memory request, held until accepted
- dm_we  out  4  byte strobes; 0000 = read
- dm_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dm_wdata  out  32  lane-aligned store data
- dm_ready  in  1  request accepted; dm_rdata valid in the same cycle
- dm_rdata  in  32  read word
- ld_data  out  32  extracted, extended load result
- ld_valid  out  1  one-cycle pulse: ld_data valid for the current instruction
- mem_stall  out  1  hold upstream stages and the execute/memory register
- misalign_exc  out  1  misaligned access detected
- misalign_addr  out  32  faulting address
- bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Access decode:
  - store = dm_w_en_reg != 0.
  - load = wb_sel_reg & wb_en_reg & !store.
  - access = store | load.
- Misaligned when:
  - halfword (store mask 0011, or func3 001/101) and addr[0] = 1;
  - word (mask 1111, or func3 010 or illegal) and addr[1:0] != 0.
- States: IDLE, REQ, DONE.
- IDLE:
  - access and misaligned: misalign_exc=1 and misalign_addr=addr, both combinational; no request, no stall; stay in IDLE.
  - access and aligned: mem_stall=1 (combinational); register dm_addr, dm_we, dm_wdata; clear wait counter; next state REQ.
  - no access: mem_stall=0.
- REQ:
  - dm_req=1, mem_stall=1; dm_addr, dm_we and dm_wdata stay stable.
  - dm_ready=1: capture the extracted dm_rdata into ld_data (loads only); next state DONE.
  - dm_ready=0: counter increments. Counter == MAX_WAIT-1 without dm_ready: drop dm_req, set bus_err flag, ld_data=0, next state DONE.
- DONE:
  - mem_stall=0; ld_valid=load; bus_err pulses if the flag is set; next state IDLE.
  - The pipeline register advances on the same edge.
- Latency: minimum 3 cycles per aligned access (IDLE, REQ with immediate ready, DONE). Each dm_ready wait cycle adds 1.
- Store alignment:
  - dm_we = dm_w_en_reg << addr[1:0].
  - dm_wdata: byte replicated x4, half replicated x2, word unchanged.
- Load extraction: shift dm_rdata right by 8*addr[1:0], then apply func3:
  - 000 sign-extend byte
  - 001 sign-extend half
  - 010 word
  - 100 zero-extend byte
  - 101 zero-extend half
  - 011/110/111 treated as word
- ld_data holds its value between captures.
- Registered outputs are 0 at reset: dm_req, dm_we, dm_addr, dm_wdata, ld_data, ld_valid, bus_err, counter; state=IDLE.
- Combinational outputs are 0 while pipeline inputs are at their reset value.
- Reset mid-access (REQ): immediate return to IDLE, dm_req deasserted asynchronously, the access is abandoned.
- dm_ready outside REQ is ignored.

Decomposition:
- Package lsu_pkg:
  - state enum (IDLE/REQ/DONE);
  - func3 constants F3_LB/LH/LW/LBU/LHU;
  - size masks SZ_B=0001, SZ_H=0011, SZ_W=1111.
- Sub-module lsu_load_align, purely combinational: rdata, addr[1:0], func3 -> extended result.
- FSM, counter and store alignment stay in mem_lsu.

Test Plan:
- SW, addr 0x100, data 0xDEADBEEF, dm_ready at first REQ cycle -> dm_we=1111, dm_addr=0x100, dm_wdata=0xDEADBEEF; mem_stall high for 2 cycles; no ld_valid.
- SB, addr 0x103, data 0x000000A5 -> dm_we=1000, dm_wdata=0xA5A5A5A5, dm_addr=0x100.
- LB/LBU/LH/LHU, addr 0x202/0x202/0x202/0x202, dm_rdata 0x80F0_1234, ready after 3 wait cycles -> LB 0xFFFFFFF0, LBU 0x000000F0, LH 0xFFFF80F0, LHU 0x000080F0; ld_valid one pulse each; stall 5 cycles each.
- LW at 0x102, then SH at 0x301 -> misalign_exc=1 with misalign_addr 0x102 then 0x301; dm_req never asserted; mem_stall=0.
- Load, dm_ready held 0, MAX_WAIT=4 -> dm_req high exactly 4 cycles, bus_err pulse, ld_data=0, return to IDLE.
- rst low during REQ -> dm_req=0 immediately; after release, a new LW at 0x0 completes normally.
